// File: rtl/delay_line_ctrl.sv
// Read-then-write sequencer for a single-port RAM variable-delay line (ADC -> DAC).
// Build option: define ECHO_MIX_EN to average the delayed and current samples (echo mix).
module delay_line_ctrl #(
    parameter int              DW      = 10,
    parameter int              AW      = 13,
    parameter logic [DW-1:0]   SILENCE = 10'd512
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic          data_valid,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] delay,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR
    } state_t;

    state_t        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] fill_q,     fill_d;
    logic [AW-1:0] d_q,        d_d;
    logic [DW-1:0] sample_q,   sample_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          overrun_q,  overrun_d;
    logic [DW-1:0] cap_val;

    // NOTE: state registers use non-blocking assignments only; the RAM itself is
    // external and deliberately left uninitialised, since fill_q masks stale words.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            d_q        <= '0;
            sample_q   <= '0;
            data_out_q <= SILENCE;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            d_q        <= d_d;
            sample_q   <= sample_d;
            data_out_q <= data_out_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef ECHO_MIX_EN
    logic [DW-1:0] mix_src;
    logic [DW:0]   mix_sum;

    always_comb begin
        mix_src = (d_q > fill_q) ? SILENCE : ram_rdata;
        mix_sum = {1'b0, sample_q} + {1'b0, mix_src};
        cap_val = (d_q == '0) ? sample_q : DW'(mix_sum >> 1);
    end
`else
    always_comb begin
        if (d_q == '0) begin
            cap_val = sample_q;
        end else if (d_q > fill_q) begin
            cap_val = SILENCE;
        end else begin
            cap_val = ram_rdata;
        end
    end
`endif

    // NOTE: every next-state signal holds its current value by default so that no
    // branch of the case statement leaves one unassigned (no inferred latches).
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        d_d        = d_q;
        sample_d   = sample_q;
        data_out_d = data_out_q;
        overrun_d  = overrun_q;

        if (data_valid && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    sample_d = data_in;
                    // delay is AW bits wide, so min(delay, DEPTH-1) is delay itself
                    d_d      = delay;
                    state_d  = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                data_out_d = cap_val;
                state_d    = ST_WR;
            end
            ST_WR: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                fill_d   = (fill_q == '1) ? fill_q : fill_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write strobe is qualified with rst so an abort during WR never commits a sample.
    always_comb begin
        ram_addr  = wr_ptr_q;
        ram_wdata = '0;
        ram_we    = 1'b0;
        out_valid = 1'b0;
        if (state_q == ST_RD) begin
            ram_addr = wr_ptr_q - d_q;
        end
        if (state_q == ST_WR) begin
            ram_wdata = sample_q;
            ram_we    = ~rst;
            out_valid = ~rst;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign data_out = data_out_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench: a default-size instance (AW=13) and a small one (AW=4) run in
// lockstep against a history-based reference model of the delay line.
module tb_delay_line_ctrl;

    localparam int DEPTH_B = 8192;
    localparam int DEPTH_S = 16;
    localparam int SIL     = 512;

    logic        sysclk;
    logic        rst;
    logic        data_valid;
    logic [9:0]  data_in;
    logic [12:0] delay_b;
    logic [3:0]  delay_s;

    logic [12:0] addr_b;
    logic        we_b, ov_b, busy_b, orun_b;
    logic [9:0]  wdata_b, rdata_b, dout_b;
    logic [3:0]  addr_s;
    logic        we_s, ov_s, busy_s, orun_s;
    logic [9:0]  wdata_s, rdata_s, dout_s;

    logic [9:0]  mem_b [DEPTH_B];
    logic [9:0]  mem_s [DEPTH_S];

    int checks;
    int errors;
    int hist [1024];
    int n;
    bit orun_exp;

    typedef struct {
        bit rst_before;
        int din;
        int dly;
        int exp_plain;
        int exp_echo;
    } vec_t;

    vec_t tbl [9];

    delay_line_ctrl u_dut_b (
        .sysclk     (sysclk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .delay      (delay_b),
        .ram_addr   (addr_b),
        .ram_we     (we_b),
        .ram_wdata  (wdata_b),
        .ram_rdata  (rdata_b),
        .data_out   (dout_b),
        .out_valid  (ov_b),
        .busy       (busy_b),
        .overrun    (orun_b)
    );

    delay_line_ctrl #(.AW(4)) u_dut_s (
        .sysclk     (sysclk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .delay      (delay_s),
        .ram_addr   (addr_s),
        .ram_we     (we_s),
        .ram_wdata  (wdata_s),
        .ram_rdata  (rdata_s),
        .data_out   (dout_s),
        .out_valid  (ov_s),
        .busy       (busy_s),
        .overrun    (orun_s)
    );

    // Single-port synchronous RAMs, read-first, one cycle of read latency.
    always @(posedge sysclk) begin
        if (we_b) mem_b[addr_b] <= wdata_b;
        rdata_b <= mem_b[addr_b];
        if (we_s) mem_s[addr_s] <= wdata_s;
        rdata_s <= mem_s[addr_s];
    end

    initial begin
        sysclk = 1'b0;
        forever #10 sysclk = ~sysclk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Output for the next sample x under delay d, given n samples stored since reset.
    function automatic int exp_out(input int d, input int depth, input int x);
        int fill;
        int y;
        fill = (n < depth - 1) ? n : depth - 1;
        if (d == 0) return x;
        y = (d > fill) ? SIL : hist[n - d];
`ifdef ECHO_MIX_EN
        return (x + y) >> 1;
`else
        return y;
`endif
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_we_b"},    int'(we_b),    0);
        check({tag, "_ov_b"},    int'(ov_b),    0);
        check({tag, "_busy_b"},  int'(busy_b),  0);
        check({tag, "_orun_b"},  int'(orun_b),  0);
        check({tag, "_dout_b"},  int'(dout_b),  SIL);
        check({tag, "_addr_b"},  int'(addr_b),  0);
        check({tag, "_wdata_b"}, int'(wdata_b), 0);
        check({tag, "_we_s"},    int'(we_s),    0);
        check({tag, "_dout_s"},  int'(dout_s),  SIL);
        check({tag, "_addr_s"},  int'(addr_s),  0);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst        = 1'b1;
        data_valid = 1'b0;
        @(negedge sysclk);
        check_reset_state("rst");
        rst      = 1'b0;
        n        = 0;
        orun_exp = 1'b0;
    endtask

    // One accepted sample: drive at negedge, accept edge T, then check RD/CAP/WR/IDLE.
    task automatic run_sample(input int x, input int db, input int ds, input int tb_b,
                              input int tb_s, input int db_late, input bit extra);
        int eb, es, rb, rs, wb, ws;
        eb = exp_out(db, DEPTH_B, x);
        es = exp_out(ds, DEPTH_S, x);
        rb = ((n - db) % DEPTH_B + DEPTH_B) % DEPTH_B;
        rs = ((n - ds) % DEPTH_S + DEPTH_S) % DEPTH_S;
        wb = n % DEPTH_B;
        ws = n % DEPTH_S;

        data_valid = 1'b1;
        data_in    = 10'(x);
        delay_b    = 13'(db);
        delay_s    = 4'(ds);
        @(negedge sysclk);
        data_valid = 1'b0;
        if (db_late >= 0) begin
            delay_b = 13'(db_late);
            delay_s = 4'(db_late);
        end
        check("rd_busy_b", int'(busy_b), 1);
        check("rd_we_b",   int'(we_b),   0);
        check("rd_ov_b",   int'(ov_b),   0);
        check("rd_addr_b", int'(addr_b), rb);
        check("rd_addr_s", int'(addr_s), rs);

        @(negedge sysclk);
        check("cap_ov_b", int'(ov_b), 0);
        check("cap_we_b", int'(we_b), 0);
        if (extra) begin
            data_valid = 1'b1;
            data_in    = 10'(x ^ 'h155);
            orun_exp   = 1'b1;
        end

        @(negedge sysclk);
        data_valid = 1'b0;
        check("wr_ov_b",    int'(ov_b),    1);
        check("wr_ov_s",    int'(ov_s),    1);
        check("wr_we_b",    int'(we_b),    1);
        check("wr_we_s",    int'(we_s),    1);
        check("wr_addr_b",  int'(addr_b),  wb);
        check("wr_addr_s",  int'(addr_s),  ws);
        check("wr_wdata_b", int'(wdata_b), x);
        check("wr_dout_b",  int'(dout_b),  eb);
        check("wr_dout_s",  int'(dout_s),  es);
        if (tb_b >= 0) check("vec_dout_b", int'(dout_b), tb_b);
        if (tb_s >= 0) check("vec_dout_s", int'(dout_s), tb_s);

        @(negedge sysclk);
        check("idle_busy_b", int'(busy_b), 0);
        check("idle_ov_b",   int'(ov_b),   0);
        check("idle_we_b",   int'(we_b),   0);
        check("idle_hold_b", int'(dout_b), eb);
        check("idle_addr_b", int'(addr_b), (n + 1) % DEPTH_B);
        check("idle_orun_b", int'(orun_b), int'(orun_exp));
        check("idle_orun_s", int'(orun_s), int'(orun_exp));

        hist[n] = x;
        n++;
    endtask

    // Reset pulse landing on the edge that ends the given phase (2 = CAP, 3 = WR).
    task automatic abort_at(input int phase, input int x);
        data_valid = 1'b1;
        data_in    = 10'(x);
        delay_b    = 13'd1;
        delay_s    = 4'd1;
        @(negedge sysclk);
        data_valid = 1'b0;
        for (int p = 2; p < phase; p++) @(negedge sysclk);
        @(negedge sysclk);
        rst = 1'b1;
        #1;
        check("abort_we_b", int'(we_b), 0);
        check("abort_ov_b", int'(ov_b), 0);
        check("abort_we_s", int'(we_s), 0);
        @(negedge sysclk);
        check_reset_state("abort");
        rst      = 1'b0;
        n        = 0;
        orun_exp = 1'b0;
        @(negedge sysclk);
        check("post_abort_we_b",  int'(we_b),  0);
        check("post_abort_ov_b",  int'(ov_b),  0);
        check("post_abort_dout_b", int'(dout_b), SIL);
    endtask

    initial begin
        int x, db, ds, late, exp_echo_pair;
        checks     = 0;
        errors     = 0;
        n          = 0;
        orun_exp   = 1'b0;
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        delay_b    = '0;
        delay_s    = '0;

        tbl[0] = '{1, 300, 0, 300, 300};
        tbl[1] = '{1,   1, 5, 512, 256};
        tbl[2] = '{0,   2, 5, 512, 257};
        tbl[3] = '{0,   3, 5, 512, 257};
        tbl[4] = '{0,   4, 5, 512, 258};
        tbl[5] = '{0,   5, 5, 512, 258};
        tbl[6] = '{0,   6, 5,   1,   3};
        tbl[7] = '{0,   7, 5,   2,   4};
        tbl[8] = '{0,   8, 5,   3,   5};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            int e;
            if (tbl[i].rst_before) do_reset();
`ifdef ECHO_MIX_EN
            e = tbl[i].exp_echo;
`else
            e = tbl[i].exp_plain;
`endif
            run_sample(tbl[i].din, tbl[i].dly, tbl[i].dly, e, e, -1, 1'b0);
        end

        // Small instance: delay 15 across the 15 -> 0 pointer wrap.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            int e;
`ifdef ECHO_MIX_EN
            e = -1;
`else
            e = (k >= 15) ? ((k - 15) * 25 + 7) % 1024 : SIL;
`endif
            run_sample((k * 25 + 7) % 1024, 15, 15, -1, e, -1, 1'b0);
        end

        // Overrun: extra pulse at T+2 dropped, flag sticks, T+4 accept is normal.
        do_reset();
        run_sample(111, 0, 0, 111, 111, -1, 1'b1);
        run_sample(222, 1, 1, -1, -1, -1, 1'b0);
        run_sample(333, 1, 1, -1, -1, -1, 1'b0);

        // Delay change during RD affects only the following sample.
        do_reset();
        for (int k = 0; k < 8; k++) run_sample(10 * (k + 1), 3, 3, -1, -1, -1, 1'b0);
`ifdef ECHO_MIX_EN
        run_sample(90, 3, 3, (90 + 60) >> 1, -1, 7, 1'b0);
        run_sample(95, 7, 7, (95 + 30) >> 1, -1, -1, 1'b0);
`else
        run_sample(90, 3, 3, 60, -1, 7, 1'b0);
        run_sample(95, 7, 7, 30, -1, -1, 1'b0);
`endif

        // Echo-mix pair: d=1, inputs 100 then 300.
        do_reset();
`ifdef ECHO_MIX_EN
        exp_echo_pair = 200;
        run_sample(100, 1, 1, (100 + SIL) >> 1, -1, -1, 1'b0);
`else
        exp_echo_pair = 100;
        run_sample(100, 1, 1, SIL, -1, -1, 1'b0);
`endif
        run_sample(300, 1, 1, exp_echo_pair, exp_echo_pair, -1, 1'b0);

        // Aborts: reset during CAP, then during WR.
        for (int k = 0; k < 3; k++) run_sample(700 + k, 0, 0, -1, -1, -1, 1'b0);
        abort_at(2, 444);
        run_sample(55, 1, 1, -1, -1, -1, 1'b0);
        run_sample(66, 0, 0, -1, -1, -1, 1'b0);
        abort_at(3, 555);
        run_sample(77, 1, 1, -1, -1, -1, 1'b0);

        // Randomised traffic against the model.
        do_reset();
        for (int k = 0; k < 150; k++) begin
            x    = int'($urandom_range(0, 1023));
            db   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8191))
                                               : int'($urandom_range(0, 20));
            ds   = int'($urandom_range(0, 15));
            late = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_sample(x, db, ds, -1, -1, late, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
